// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, one clocked write port and a
// per-register busy scoreboard that raises Stall on a RAW hazard.
module regfile_scoreboard #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [AW-1:0]    RS,
  input  logic [AW-1:0]    RT,
  input  logic             UseRS,
  input  logic             UseRT,
  output logic [WIDTH-1:0] ReadRS,
  output logic [WIDTH-1:0] ReadRT,
  input  logic [AW-1:0]    RD,
  input  logic             RegWrite,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             IssueValid,
  input  logic [AW-1:0]    IssueRD,
  output logic             Stall,
  output logic [DEPTH-1:0] BusyMask
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic rsIsZero, rtIsZero;
  logic rsMatchWr, rtMatchWr;
  logic writeEn, issueEn;
  logic hzA, hzB;

  assign rsIsZero  = ZERO_REG && (RS == '0);
  assign rtIsZero  = ZERO_REG && (RT == '0);
  assign rsMatchWr = BYPASS && RegWrite && (RD == RS);
  assign rtMatchWr = BYPASS && RegWrite && (RD == RT);

  assign writeEn = RegWrite && !(ZERO_REG && (RD == '0));
  assign issueEn = IssueValid && !Stall && !(ZERO_REG && (IssueRD == '0));

  // Busy is cleared asynchronously, so no explicit Reset gating is needed here.
  assign hzA   = UseRS && busy[RS] && !rsMatchWr;
  assign hzB   = UseRT && busy[RT] && !rtMatchWr;
  assign Stall = hzA || hzB;

  assign BusyMask = busy;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (writeEn) begin
        regs[RD] <= WriteData;
        busy[RD] <= 1'b0;
      end
      // Issued after the write so a same-edge set wins over the clear.
      if (issueEn) busy[IssueRD] <= 1'b1;
    end
  end

  always_comb begin
    ReadRS = regs[RS];
    if (rsIsZero)                 ReadRS = '0;
    else if (rsMatchWr && !Reset) ReadRS = WriteData;
  end

  always_comb begin
    ReadRT = regs[RT];
    if (rtIsZero)                 ReadRT = '0;
    else if (rtMatchWr && !Reset) ReadRT = WriteData;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default build, a no-bypass build sharing its stimulus,
// and a wide/deep build without a hardwired R0.
module tb_regfile_scoreboard;

  logic Clock;
  logic Reset;

  // Shared stimulus for the 16x8 builds (A: bypass, B: no bypass)
  logic [2:0]  RS, RT, RD, IssueRD;
  logic        UseRS, UseRT, RegWrite, IssueValid;
  logic [15:0] WriteData;
  logic [15:0] aReadRS, aReadRT, bReadRS, bReadRT;
  logic        aStall, bStall;
  logic [7:0]  aBusy, bBusy;

  // 32x16, no zero register
  logic [3:0]  cRS, cRT, cRD, cIssueRD;
  logic        cUseRS, cUseRT, cRegWrite, cIssueValid;
  logic [31:0] cWriteData;
  logic [31:0] cReadRS, cReadRT;
  logic        cStall;
  logic [15:0] cBusy;

  int testCount = 0;
  int failCount = 0;

  regfile_scoreboard dutA (
    .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .UseRS(UseRS), .UseRT(UseRT),
    .ReadRS(aReadRS), .ReadRT(aReadRT), .RD(RD), .RegWrite(RegWrite),
    .WriteData(WriteData), .IssueValid(IssueValid), .IssueRD(IssueRD),
    .Stall(aStall), .BusyMask(aBusy)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) dutB (
    .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .UseRS(UseRS), .UseRT(UseRT),
    .ReadRS(bReadRS), .ReadRT(bReadRT), .RD(RD), .RegWrite(RegWrite),
    .WriteData(WriteData), .IssueValid(IssueValid), .IssueRD(IssueRD),
    .Stall(bStall), .BusyMask(bBusy)
  );

  regfile_scoreboard #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1'b0)) dutC (
    .Clock(Clock), .Reset(Reset), .RS(cRS), .RT(cRT), .UseRS(cUseRS), .UseRT(cUseRT),
    .ReadRS(cReadRS), .ReadRT(cReadRT), .RD(cRD), .RegWrite(cRegWrite),
    .WriteData(cWriteData), .IssueValid(cIssueValid), .IssueRD(cIssueRD),
    .Stall(cStall), .BusyMask(cBusy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    RS = '0; RT = '0; RD = '0; IssueRD = '0;
    UseRS = 0; UseRT = 0; RegWrite = 0; IssueValid = 0; WriteData = '0;
    cRS = '0; cRT = '0; cRD = '0; cIssueRD = '0;
    cUseRS = 0; cUseRT = 0; cRegWrite = 0; cIssueValid = 0; cWriteData = '0;
    tick(); tick();
    checkVal("rstBusy", aBusy, 8'h00);
    checkVal("rstRead", aReadRS, 16'h0000);
    checkVal("rstStall", aStall, 1'b0);
    Reset = 1'b0;

    // Basic write/read; issue R7 alongside the R3 write
    RegWrite = 1; RD = 3'd2; WriteData = 16'h0005;
    tick();
    RD = 3'd3; WriteData = 16'h0007; IssueValid = 1; IssueRD = 3'd7;
    tick();
    RegWrite = 0; IssueValid = 0; RS = 3'd2; RT = 3'd3;
    #1;
    checkVal("rdA_R2", aReadRS, 16'h0005);
    checkVal("rdA_R3", aReadRT, 16'h0007);
    checkVal("rdB_R2", bReadRS, 16'h0005);
    checkVal("busyR7", aBusy, 8'h80);
    RT = 3'd7; UseRT = 1;
    #1;
    checkVal("stallR7A", aStall, 1'b1);
    checkVal("stallR7B", bStall, 1'b1);

    // Async reset mid-run, with a write attempted while held
    Reset = 1; RegWrite = 1; RD = 3'd2; WriteData = 16'hAAAA;
    #1;
    checkVal("inRstRead", aReadRS, 16'h0000);
    checkVal("inRstBusy", aBusy, 8'h00);
    checkVal("inRstStall", aStall, 1'b0);
    tick();
    Reset = 0; RegWrite = 0; UseRT = 0;
    #1;
    checkVal("postRstR2", aReadRS, 16'h0000);
    RegWrite = 1; RD = 3'd2; WriteData = 16'h0005;
    tick();
    RegWrite = 0;
    #1;
    checkVal("reWriteR2", aReadRS, 16'h0005);

    // Hardwired R0: write and issue both ignored
    RegWrite = 1; RD = 3'd0; WriteData = 16'hFFFF; RS = 3'd0;
    IssueValid = 1; IssueRD = 3'd0;
    #1;
    checkVal("r0Bypass", aReadRS, 16'h0000);
    tick();
    RegWrite = 0; IssueValid = 0;
    #1;
    checkVal("r0Read", aReadRS, 16'h0000);
    checkVal("r0Busy", aBusy, 8'h00);

    // Same-cycle bypass
    RegWrite = 1; RD = 3'd4; WriteData = 16'h1234; RS = 3'd4;
    #1;
    checkVal("bypassA", aReadRS, 16'h1234);
    checkVal("noBypassB", bReadRS, 16'h0000);
    tick();
    RegWrite = 0;
    #1;
    checkVal("lateB_R4", bReadRS, 16'h1234);

    // Scoreboard on R5
    IssueValid = 1; IssueRD = 3'd5;
    tick();
    IssueValid = 0;
    #1;
    checkVal("busyR5A", aBusy, 8'h20);
    checkVal("busyR5B", bBusy, 8'h20);
    RS = 3'd5; UseRS = 1;
    #1;
    checkVal("stallR5", aStall, 1'b1);
    UseRS = 0;
    #1;
    checkVal("noUseStall", aStall, 1'b0);
    UseRS = 1; RegWrite = 1; RD = 3'd5; WriteData = 16'h0009;
    #1;
    checkVal("wbStallA", aStall, 1'b0);
    checkVal("wbReadA", aReadRS, 16'h0009);
    checkVal("wbStallB", bStall, 1'b1);
    tick();
    RegWrite = 0;
    #1;
    checkVal("clrBusyA", aBusy, 8'h00);
    checkVal("clrBusyB", bBusy, 8'h00);
    checkVal("clrStallB", bStall, 1'b0);
    checkVal("wbReadB", bReadRS, 16'h0009);

    // Same-edge write and issue to R6: set wins, data still lands
    UseRS = 0; RegWrite = 1; RD = 3'd6; WriteData = 16'h0003;
    IssueValid = 1; IssueRD = 3'd6;
    tick();
    RegWrite = 0; IssueValid = 0; RS = 3'd6;
    #1;
    checkVal("setWinsBusy", aBusy, 8'h40);
    checkVal("setWinsData", aReadRS, 16'h0003);

    // Issue while stalled is dropped
    UseRS = 1; IssueValid = 1; IssueRD = 3'd1;
    #1;
    checkVal("stallR6", aStall, 1'b1);
    tick();
    IssueValid = 0; UseRS = 0;
    #1;
    checkVal("droppedIssue", aBusy, 8'h40);

    // Wide/deep build: R0 is an ordinary register
    cRegWrite = 1; cRD = 4'd0; cWriteData = 32'hDEADBEEF; cRS = 4'd0;
    #1;
    checkVal("cR0Bypass", cReadRS, 32'hDEADBEEF);
    tick();
    cRegWrite = 0;
    #1;
    checkVal("cR0Read", cReadRS, 32'hDEADBEEF);
    cIssueValid = 1; cIssueRD = 4'd15;
    tick();
    cIssueValid = 0;
    #1;
    checkVal("cBusyR15", cBusy, 16'h8000);
    cRS = 4'd15; cUseRS = 1;
    #1;
    checkVal("cStallR15", cStall, 1'b1);
    cRegWrite = 1; cRD = 4'd15; cWriteData = 32'h12345678;
    #1;
    checkVal("cWbStall", cStall, 1'b0);
    checkVal("cWbRead", cReadRS, 32'h12345678);
    tick();
    cRegWrite = 0; cUseRS = 0;
    #1;
    checkVal("cClrBusy", cBusy, 16'h0000);
    checkVal("cR15Read", cReadRS, 32'h12345678);
    cIssueValid = 1; cIssueRD = 4'd0;
    tick();
    cIssueValid = 0;
    #1;
    checkVal("cBusyR0", cBusy, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the CPU's 8 x 16-bit register file. It provides two combinational read ports and one clocked write port. Write-to-read bypass and an optional hardwired-zero R0 are selectable by parameter. A per-register busy scoreboard tracks in-flight producers and raises a hazard stall to the issue stage. It sits between decode/issue (read ports, issue marking) and writeback (write port).

## Interface
Parameters:
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers; power of two, >= 2
- AW, $clog2(DEPTH), register address width (derived; do not override)
- ZERO_REG, 1, 1 = R0 reads 0, ignores writes and never becomes busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and to stall logic

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all registers and busy bits
- RS  in  AW  read port A address
- RT  in  AW  read port B address
- UseRS  in  1  instruction actually sources RS (qualifies stall)
- UseRT  in  1  instruction actually sources RT
- ReadRS  out  WIDTH  read data A
- ReadRT  out  WIDTH  read data B
- RD  in  AW  write address
- RegWrite  in  1  write enable
- WriteData  in  WIDTH  write data
- IssueValid  in  1  an instruction with a destination is issuing this cycle
- IssueRD  in  AW  destination of the issuing instruction
- Stall  out  1  RAW hazard on a used source; issue stage must hold
- BusyMask  out  DEPTH  registered busy bit per register (bit i = register i)

## Operation
- Storage: DEPTH x WIDTH flops, plus a DEPTH-bit busy vector.
- Write: at rising Clock, if RegWrite and not (ZERO_REG and RD==0): reg[RD] <= WriteData; busy[RD] <= 0.
- Issue: at rising Clock, if IssueValid and !Stall and not (ZERO_REG and IssueRD==0): busy[IssueRD] <= 1.
- IssueValid while Stall=1 is ignored; the busy vector is unchanged.
- Same-edge write and issue to the same register: set wins (busy=1), and the data is still written.
- Issue to an already-busy register (WAW) is allowed; busy stays 1 and is cleared by the next write to that register.
- Read (combinational) for port A:
  - If ZERO_REG and RS==0, ReadRS = 0.
  - Else if BYPASS and RegWrite and RD==RS and !Reset, ReadRS = WriteData.
  - Else ReadRS = reg[RS].
  - Port B is identical using RT.
- Stall (combinational) = hzA | hzB, where hzA = UseRS & busy[RS] & !(BYPASS & RegWrite & RD==RS).
  - With ZERO_REG, busy[0] is constant 0.
  - With BYPASS=0, a writeback does not clear the hazard until the following cycle.
- BusyMask = busy vector, registered.

## Timing
- Reset (async): all reg = 0 and busy = 0 immediately on assertion. While Reset is high:
  - ReadRS = ReadRT = 0
  - Stall = 0, BusyMask = 0
  - writes and issues are ignored
- Reset deasserted mid-operation: the first active edge after deassertion behaves normally. No state survives from before reset.
- Write latency:
  - Array read sees the new value from the cycle after the edge.
  - With BYPASS=1, the read ports also see it in the same cycle as RegWrite.
- Busy set by an issue at edge N is visible on BusyMask/Stall from cycle N+1.
- A busy clear by a write at edge N is visible from N+1. With BYPASS=1, Stall already drops during the write cycle.
- Address wrap: all addresses are AW bits, so no out-of-range case exists.

## Test plan
- Reset/defaults (WIDTH=16, DEPTH=8): assert Reset mid-run after writing R2=5 -> ReadRS(RS=2)=0 immediately, BusyMask=0, Stall=0; deassert, write R2=0x0005 -> next cycle ReadRS=0x0005.
- Basic write/read: write R2=5, R3=7 on consecutive edges, RegWrite low afterwards; RS=2, RT=3 -> ReadRS=5, ReadRT=7.
- Zero register and bypass:
  - ZERO_REG=1: write R0=0xFFFF -> ReadRS(RS=0)=0; IssueRD=0 -> BusyMask bit0 stays 0.
  - BYPASS=1: RegWrite with RD=4, WriteData=0x1234, and RS=4 in the same cycle -> ReadRS=0x1234 before the edge.
- Scoreboard:
  - Issue R5 -> BusyMask=0x20 next cycle.
  - RS=5, UseRS=1 -> Stall=1.
  - UseRS=0 -> Stall=0.
  - Writeback R5=9 with BYPASS=1 -> Stall=0 that cycle, ReadRS=9, BusyMask=0 next cycle.
  - Repeat with BYPASS=0 -> Stall stays 1 through the write cycle and drops the cycle after.
- Simultaneous events:
  - Same edge: write R6=3 and issue R6 -> BusyMask bit6=1, reg R6=3.
  - IssueValid=1 with IssueRD=1 while Stall=1 (RS busy) -> bit1 stays 0.
- Parameter sweep: WIDTH=32, DEPTH=16, ZERO_REG=0 -> R0 writable (write R0=0xDEADBEEF, read back) and R15 write/issue/clear behaves as above.
